fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 16'h0800, meaning instruction injected on flush/bubble.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port stall, input, 1 bit: hold PC and IF/ID register this cycle.
REQ-006 SHALL have port redirect, input, 1 bit: taken branch/jump; load redirect_pc, squash fetched instruction.
REQ-007 SHALL have port redirect_pc, input, 16 bits: target address.
REQ-008 SHALL have port imem_addr, output, 16 bits: address to instruction memory (PC, bit 0 always 0).
REQ-009 SHALL have port imem_en, output, 1 bit: instruction memory read enable.
REQ-010 SHALL have port imem_wr, output, 1 bit: instruction memory write; tied 0.
REQ-011 SHALL have port imem_data, input, 16 bits: combinational read data from instruction memory.
REQ-012 SHALL have port id_instr, output, 16 bits: registered instruction to decode.
REQ-013 SHALL have port id_pc_plus2, output, 16 bits: registered PC+2 of id_instr.
REQ-014 SHALL have port id_valid, output, 1 bit: id_instr is a real fetched instruction.
REQ-015 SHALL have port halted, output, 1 bit: fetch stopped on HALT.

Function
REQ-016 SHALL contain a 16-bit PC register and a two-state FSM: RUN, HALTED.
REQ-017 SHALL drive imem_addr = {pc[15:1],1'b0}; imem_en = 1 in RUN and not rst, else 0.
REQ-018 SHALL detect HALT when imem_data[15:11] == 5'b00000 while in RUN.
REQ-019 SHALL apply per-edge priority: rst > redirect > stall > HALT detect > normal fetch.
REQ-020 Normal fetch: pc <= pc+2 (mod 2^16, 16'hFFFE wraps to 16'h0000); id_instr <= imem_data; id_pc_plus2 <= pc+2; id_valid <= 1.
REQ-021 Redirect (any state): pc <= {redirect_pc[15:1],0}; id_instr <= NOP_INSTR; id_valid <= 0; state <= RUN.
REQ-022 Stall without redirect: pc, id_instr, id_pc_plus2, id_valid, state all hold.
REQ-023 HALT detect (no redirect/stall): HALT word latched into id_instr with id_valid=1, id_pc_plus2 <= pc+2; pc holds; state <= HALTED.
REQ-024 HALTED: pc holds; imem_en=0; id_instr <= NOP_INSTR, id_valid <= 0 each unstalled cycle; halted=1; exit only by redirect or rst.
REQ-025 Fetch latency: instruction at address A appears on id_instr one edge after pc==A with no stall/redirect.
REQ-026 Stall and redirect in same cycle: redirect wins; no instruction lost beyond the squashed one.
REQ-027 HALT fetched while stall=1: not recognized that cycle; recognized on first unstalled cycle.
REQ-028 halted SHALL be combinational from state (1 iff HALTED).

Reset
REQ-029 On rst=1 at clock edge: pc <= RESET_PC with bit 0 cleared, state <= RUN, id_instr <= NOP_INSTR, id_pc_plus2 <= 0, id_valid <= 0.
REQ-030 While rst=1: imem_en=0, imem_wr=0, halted=0; rst overrides redirect and stall.
REQ-031 Reset mid-operation (incl. HALTED) SHALL return to RUN at RESET_PC on the next edge.

Verification
REQ-032 Memory 0x0000..0x0006 = 4000,4001,4002,0000; release rst -> id_instr 4000,4001,4002,0000 on successive edges, id_pc_plus2 2,4,6,8, then halted=1, id_valid=0, pc=0x0006.
REQ-033 Stall=1 for 3 cycles after first fetch -> pc=0x0002 and id_instr=4000 held 3 cycles, then fetch resumes at 4001.
REQ-034 redirect=1, redirect_pc=0x0101 at pc=0x0004 -> next edge pc=0x0100, id_valid=0, id_instr=0800; following edge id_instr=mem[0x0100].
REQ-035 redirect and stall both 1 -> redirect taken, pc=target, id_valid=0.
REQ-036 In HALTED, redirect to 0x0010 -> state RUN, halted=0, fetch from 0x0010; separately rst in HALTED -> pc=0x0000, halted=0.
REQ-037 pc=0xFFFE holding non-HALT -> after fetch pc=0x0000, id_pc_plus2=0x0000.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction memory bus between the fetch stage and instruction memory.
//   imem_addr : word-aligned fetch address (bit 0 always 0)
//   imem_en   : read enable
//   imem_wr   : write strobe, never asserted by fetch
//   imem_data : combinational read data returned by memory
// master: fetch side. slave: memory side.
interface fetch_stage_if;
    logic [15:0] imem_addr;
    logic        imem_en;
    logic        imem_wr;
    logic [15:0] imem_data;

    modport master (
        output imem_addr,
        output imem_en,
        output imem_wr,
        input  imem_data
    );

    modport slave (
        input  imem_addr,
        input  imem_en,
        input  imem_wr,
        output imem_data
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: 16-bit PC, IF/ID pipeline register and a
// RUN/HALTED state machine. Fetch stops when a HALT word (opcode bits
// [15:11] all zero) reaches decode, and resumes only on redirect or reset.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   stall        : hold PC and IF/ID register this cycle
//   redirect     : taken branch/jump; load redirect_pc, squash fetch
//   redirect_pc  : redirect target (bit 0 ignored)
//   imem         : instruction memory bus (master side)
//   id_instr     : registered instruction to decode
//   id_pc_plus2  : registered PC+2 of id_instr
//   id_valid     : id_instr is a real fetched instruction
//   halted       : fetch stopped on HALT
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [15:0]          redirect_pc,
    fetch_stage_if.master        imem,
    output logic [15:0]          id_instr,
    output logic [15:0]          id_pc_plus2,
    output logic                 id_valid,
    output logic                 halted
);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    localparam logic [15:0] RESET_PC_ALIGNED = RESET_PC & 16'hFFFE;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        is_halt;

    assign pc_plus2 = pc + 16'd2;
    assign is_halt  = (imem.imem_data[15:11] == 5'b00000);

    assign imem.imem_addr = {pc[15:1], 1'b0};
    assign imem.imem_en   = (state == RUN) && !rst;
    assign imem.imem_wr   = 1'b0;
    assign halted         = (state == HALTED);

    // Priority: rst > redirect > stall > HALT detect > normal fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC_ALIGNED;
            state       <= RUN;
            id_instr    <= NOP_INSTR;
            id_pc_plus2 <= '0;
            id_valid    <= 1'b0;
        end else if (redirect) begin
            // id_pc_plus2 is left untouched: the squashed slot is invalid.
            pc       <= {redirect_pc[15:1], 1'b0};
            state    <= RUN;
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
        end else if (stall) begin
            pc          <= pc;
            state       <= state;
            id_instr    <= id_instr;
            id_pc_plus2 <= id_pc_plus2;
            id_valid    <= id_valid;
        end else begin
            case (state)
                RUN: begin
                    id_instr    <= imem.imem_data;
                    id_pc_plus2 <= pc_plus2;
                    id_valid    <= 1'b1;
                    if (is_halt) begin
                        // HALT reaches decode as a valid instruction; PC parks on it.
                        state <= HALTED;
                    end else begin
                        pc <= pc_plus2;
                    end
                end
                HALTED: begin
                    id_instr <= NOP_INSTR;
                    id_valid <= 1'b0;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. Directed stimulus pushes the
// hand-computed post-edge state into a scoreboard queue; a monitor pops
// one entry after each rising edge and compares all observable outputs.
module tb_fetch_stage;

    typedef struct {
        int          id;
        logic [15:0] instr;
        logic [15:0] pc2;
        logic        chk_pc2;
        logic        valid;
        logic [15:0] addr;
        logic        en;
        logic        hlt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] id_instr;
    logic [15:0] id_pc_plus2;
    logic        id_valid;
    logic        halted;

    logic [15:0] mem [0:32767];

    exp_t exp_q[$];
    int   total;
    int   bad;
    int   step_id;

    fetch_stage_if imem_bus ();

    assign imem_bus.imem_data = mem[imem_bus.imem_addr[15:1]];

    fetch_stage #(
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0800)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem_bus.master),
        .id_instr    (id_instr),
        .id_pc_plus2 (id_pc_plus2),
        .id_valid    (id_valid),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input int id, input string what,
                         input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL step%0d %s: got=%h want=%h", id, what, got, want);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the edge.
    task automatic step(input logic r, input logic s, input logic rd,
                        input logic [15:0] rpc,
                        input logic [15:0] e_instr, input logic [15:0] e_pc2,
                        input logic e_chk_pc2, input logic e_valid,
                        input logic [15:0] e_addr, input logic e_en,
                        input logic e_hlt);
        exp_t e;
        @(negedge clk);
        rst         = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
        step_id++;
        e.id      = step_id;
        e.instr   = e_instr;
        e.pc2     = e_pc2;
        e.chk_pc2 = e_chk_pc2;
        e.valid   = e_valid;
        e.addr    = e_addr;
        e.en      = e_en;
        e.hlt     = e_hlt;
        exp_q.push_back(e);
    endtask

    // Monitor: compare after every edge for which an expectation is queued.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.id, "id_instr", id_instr, e.instr);
            if (e.chk_pc2) check(e.id, "id_pc_plus2", id_pc_plus2, e.pc2);
            check(e.id, "id_valid", {15'd0, id_valid}, {15'd0, e.valid});
            check(e.id, "imem_addr", imem_bus.imem_addr, e.addr);
            check(e.id, "imem_en", {15'd0, imem_bus.imem_en}, {15'd0, e.en});
            check(e.id, "imem_wr", {15'd0, imem_bus.imem_wr}, 16'd0);
            check(e.id, "halted", {15'd0, halted}, {15'd0, e.hlt});
        end
    end

    initial begin
        int wait_cycles;
        total   = 0;
        bad     = 0;
        step_id = 0;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        // Non-HALT fill: 0x4000 | word index; word 3 (addr 0x0006) is HALT.
        for (int unsigned i = 0; i < 32768; i++) mem[i] = 16'h4000 | (16'(i) & 16'h03FF);
        mem[3] = 16'h0000;

        //   rst stl rd  rpc      instr     pc2    chk valid addr     en  hlt
        step(1, 0, 0, 16'h0000, 16'h0800, 16'h0000, 1, 0, 16'h0000, 0, 0);
        step(1, 0, 0, 16'h0000, 16'h0800, 16'h0000, 1, 0, 16'h0000, 0, 0);
        // Straight-line fetch into HALT
        step(0, 0, 0, 16'h0000, 16'h4000, 16'h0002, 1, 1, 16'h0002, 1, 0);
        step(0, 0, 0, 16'h0000, 16'h4001, 16'h0004, 1, 1, 16'h0004, 1, 0);
        step(0, 0, 0, 16'h0000, 16'h4002, 16'h0006, 1, 1, 16'h0006, 1, 0);
        step(0, 0, 0, 16'h0000, 16'h0000, 16'h0008, 1, 1, 16'h0006, 0, 1);
        step(0, 0, 0, 16'h0000, 16'h0800, 16'h0008, 1, 0, 16'h0006, 0, 1);
        // Reset while HALTED, with redirect also asserted on a later reset
        step(1, 0, 0, 16'h0000, 16'h0800, 16'h0000, 1, 0, 16'h0000, 0, 0);
        // Stall for three cycles after first fetch
        step(0, 0, 0, 16'h0000, 16'h4000, 16'h0002, 1, 1, 16'h0002, 1, 0);
        step(0, 1, 0, 16'h0000, 16'h4000, 16'h0002, 1, 1, 16'h0002, 1, 0);
        step(0, 1, 0, 16'h0000, 16'h4000, 16'h0002, 1, 1, 16'h0002, 1, 0);
        step(0, 1, 0, 16'h0000, 16'h4000, 16'h0002, 1, 1, 16'h0002, 1, 0);
        step(0, 0, 0, 16'h0000, 16'h4001, 16'h0004, 1, 1, 16'h0004, 1, 0);
        // Redirect to 0x0101 from pc 0x0004: bit 0 dropped
        step(0, 0, 1, 16'h0101, 16'h0800, 16'h0000, 0, 0, 16'h0100, 1, 0);
        step(0, 0, 0, 16'h0000, 16'h4080, 16'h0102, 1, 1, 16'h0102, 1, 0);
        // Redirect and stall together: redirect wins
        step(0, 1, 1, 16'h0200, 16'h0800, 16'h0000, 0, 0, 16'h0200, 1, 0);
        step(0, 0, 0, 16'h0000, 16'h4100, 16'h0202, 1, 1, 16'h0202, 1, 0);
        // Go back to HALT; HALT under stall is not recognised
        step(0, 0, 1, 16'h0006, 16'h0800, 16'h0000, 0, 0, 16'h0006, 1, 0);
        step(0, 1, 0, 16'h0000, 16'h0800, 16'h0000, 0, 0, 16'h0006, 1, 0);
        step(0, 0, 0, 16'h0000, 16'h0000, 16'h0008, 1, 1, 16'h0006, 0, 1);
        step(0, 1, 0, 16'h0000, 16'h0000, 16'h0008, 1, 1, 16'h0006, 0, 1);
        step(0, 0, 0, 16'h0000, 16'h0800, 16'h0008, 1, 0, 16'h0006, 0, 1);
        // Redirect out of HALTED to 0x0010
        step(0, 0, 1, 16'h0010, 16'h0800, 16'h0000, 0, 0, 16'h0010, 1, 0);
        step(0, 0, 0, 16'h0000, 16'h4008, 16'h0012, 1, 1, 16'h0012, 1, 0);
        // PC wrap at 0xFFFE
        step(0, 0, 1, 16'hFFFF, 16'h0800, 16'h0000, 0, 0, 16'hFFFE, 1, 0);
        step(0, 0, 0, 16'h0000, 16'h43FF, 16'h0000, 1, 1, 16'h0000, 1, 0);
        step(0, 0, 0, 16'h0000, 16'h4000, 16'h0002, 1, 1, 16'h0002, 1, 0);
        // Reset overrides redirect and stall
        step(1, 1, 1, 16'h0100, 16'h0800, 16'h0000, 1, 0, 16'h0000, 0, 0);
        step(0, 0, 0, 16'h0000, 16'h4000, 16'h0002, 1, 1, 16'h0002, 1, 0);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
